// File: rtl/lb_frame_sequencer_if.sv
`timescale 1ns/1ps
// Pixel-stream input and window-beat output of the line-buffer front end.
// slave: the sequencer side; master: the pixel source and window consumer.
interface lb_frame_sequencer_if #(
   parameter int WIDTH      = 320,
   parameter int HEIGHT     = 240,
   parameter int DATA_WIDTH = 12
);
   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);

   logic signed [DATA_WIDTH-1:0] s_data;
   logic                         s_valid;
   logic                         s_ready;
   logic                         s_sof;
   logic                         s_eol;
   logic                         m_valid;
   logic                         m_ready;
   logic [CW-1:0]                m_x;
   logic [RW-1:0]                m_y;
   logic                         m_eol;
   logic                         m_eof;

   modport master (
      output s_data, s_valid, s_sof, s_eol, m_ready,
      input  s_ready, m_valid, m_x, m_y, m_eol, m_eof
   );

   modport slave (
      input  s_data, s_valid, s_sof, s_eol, m_ready,
      output s_ready, m_valid, m_x, m_y, m_eol, m_eof
   );
endinterface

// File: rtl/lb_frame_sequencer.sv
`timescale 1ns/1ps
// Line-buffer front end: tracks frame position, emits one beat per full 5x5 window one cycle
// after the completing pixel, and stalls the source while a beat waits; framing errors pulse lb_rst_n.
module lb_frame_sequencer #(
   parameter int WIDTH      = 320,
   parameter int HEIGHT     = 240,
   parameter int DATA_WIDTH = 12
) (
   input  logic                         clk,
   input  logic                         rst_n,
   lb_frame_sequencer_if.slave          bus,
   output logic signed [DATA_WIDTH-1:0] lb_data,
   output logic                         lb_valid,
   output logic                         lb_rst_n,
   output logic                         frame_done,
   output logic                         err_sync,
   output logic                         busy
);
   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
   localparam logic [CW-1:0] COL_WIN  = CW'(4);
   localparam logic [RW-1:0] ROW_WIN  = RW'(4);

   typedef enum logic [1:0] {IDLE, RUN, RESYNC} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_col, w_col_nxt;
   logic [RW-1:0] r_row, w_row_nxt;
   logic          r_m_valid;
   logic [CW-1:0] r_m_x;
   logic [RW-1:0] r_m_y;
   logic          r_m_eol;
   logic          r_m_eof;
   logic          r_frame_done;
   logic          r_err_sync;
   logic          r_resync_q;

   logic w_stall, w_s_ready, w_accept, w_take, w_err, w_frame_end, w_win;
   logic w_col_last, w_row_last;

   assign w_stall    = r_m_valid && !bus.m_ready;
   assign w_s_ready  = ((r_state == IDLE) || (r_state == RUN)) && !w_stall;
   assign w_accept   = bus.s_valid && w_s_ready;
   assign w_col_last = (r_col == COL_LAST);
   assign w_row_last = (r_row == ROW_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_col_nxt   = r_col;
      w_row_nxt   = r_row;
      w_take      = 1'b0;
      w_err       = 1'b0;
      w_frame_end = 1'b0;
      case (r_state)
         IDLE: begin
            // Anything other than a start-of-frame is discarded while hunting.
            if (w_accept && bus.s_sof) begin
               w_take      = 1'b1;
               w_state_nxt = RUN;
               w_col_nxt   = CW'(1);
               w_row_nxt   = '0;
            end
         end
         RUN: begin
            if (w_accept) begin
               if (bus.s_sof || (bus.s_eol != w_col_last)) begin
                  w_err       = 1'b1;
                  w_state_nxt = RESYNC;
                  w_col_nxt   = '0;
                  w_row_nxt   = '0;
               end else begin
                  w_take = 1'b1;
                  if (w_col_last) begin
                     w_col_nxt = '0;
                     if (w_row_last) begin
                        w_row_nxt   = '0;
                        w_frame_end = 1'b1;
                        w_state_nxt = IDLE;
                     end else begin
                        w_row_nxt = r_row + RW'(1);
                     end
                  end else begin
                     w_col_nxt = r_col + CW'(1);
                  end
               end
            end
         end
         RESYNC: begin
            w_state_nxt = IDLE;
            w_col_nxt   = '0;
            w_row_nxt   = '0;
         end
         default: begin
            w_state_nxt = IDLE;
            w_col_nxt   = '0;
            w_row_nxt   = '0;
         end
      endcase
   end

   // A window is complete once at least five rows and five columns have been written.
   assign w_win = w_take && (r_col >= COL_WIN) && (r_row >= ROW_WIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_col        <= '0;
         r_row        <= '0;
         r_frame_done <= 1'b0;
         r_err_sync   <= 1'b0;
         r_resync_q   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_col        <= w_col_nxt;
         r_row        <= w_row_nxt;
         r_frame_done <= w_frame_end;
         r_err_sync   <= w_err;
         r_resync_q   <= w_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_valid <= 1'b0;
         r_m_x     <= '0;
         r_m_y     <= '0;
         r_m_eol   <= 1'b0;
         r_m_eof   <= 1'b0;
      end else if (w_win) begin
         r_m_valid <= 1'b1;
         r_m_x     <= r_col - CW'(2);
         r_m_y     <= r_row - RW'(2);
         r_m_eol   <= w_col_last;
         r_m_eof   <= w_col_last && w_row_last;
      end else if (w_err || (r_state == RESYNC) || bus.m_ready) begin
         r_m_valid <= 1'b0;
      end
   end

   assign bus.s_ready = w_s_ready;
   assign bus.m_valid = r_m_valid;
   assign bus.m_x     = r_m_x;
   assign bus.m_y     = r_m_y;
   assign bus.m_eol   = r_m_eol;
   assign bus.m_eof   = r_m_eof;

   assign lb_data    = bus.s_data;
   assign lb_valid   = w_take;
   assign lb_rst_n   = rst_n && !r_resync_q;
   assign frame_done = r_frame_done;
   assign err_sync   = r_err_sync;
   assign busy       = (r_state != IDLE);
endmodule
